pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter START_ADDR, default 4'h0, meaning the address loaded on start and on wrap.
REQ-002 SHALL have parameter LAST_ADDR, default 4'hF, meaning the final address before wrap to START_ADDR.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high; it is sampled only on the rising clock edge.
REQ-005 SHALL have port start, input, 1, begin sequencing from IDLE or HALTED.
REQ-006 SHALL have port stall, input, 1, hold the current address (pipeline stall).
REQ-007 SHALL have port branch_req, input, 1, redirect to branch_target.
REQ-008 SHALL have port branch_target, input, 4, branch destination address.
REQ-009 SHALL have port halt, input, 1, stop sequencing and hold the address.
REQ-010 SHALL have port count_in, input, 4, the current counter value fed back from the counter output.
REQ-011 SHALL have port counter_enable, output, 1, counter enable; 0 clears the counter on the next edge.
REQ-012 SHALL have port operation, output, 2, counter op: 00 load value, 01 hold, 10 value+1, 11 value-1.
REQ-013 SHALL have port value, output, 4, counter data operand.
REQ-014 SHALL have port fetch_valid, output, 1, count_in is a valid fetch address this cycle.
REQ-015 SHALL have port wrap, output, 1, one-cycle pulse when the address wraps LAST_ADDR to START_ADDR.
REQ-016 SHALL have port busy, output, 1, high in LOAD, RUN and BRANCH.
REQ-017 SHALL have port done, output, 1, high in HALTED.

Function
REQ-018 SHALL implement a registered FSM with the states IDLE=000, LOAD=001, RUN=010, BRANCH=011 and HALTED=100; encodings 101-111 SHALL return to IDLE on the next edge.
REQ-019 SHALL drive all outputs combinationally from the current state and the current inputs (Mealy), so the counter applies the op on the same edge as the state update.
REQ-020 SHALL, in IDLE, drive: counter_enable=0, operation=01, value=0, fetch_valid=0, wrap=0, busy=0, done=0.
REQ-021 SHALL, in IDLE, go to LOAD when start=1; otherwise it SHALL remain in IDLE.
REQ-022 SHALL, in LOAD, drive counter_enable=1, operation=00, value=START_ADDR and fetch_valid=0, then go to RUN unconditionally.
REQ-023 SHALL, in RUN, apply the priority halt > branch_req > stall > advance.
REQ-024 SHALL, in RUN with halt=1, drive operation=01 and fetch_valid=1, then go to HALTED.
REQ-025 SHALL, in RUN with branch_req=1 and halt=0, drive operation=00, value=branch_target and fetch_valid=0, then go to BRANCH.
REQ-026 SHALL, in RUN with stall=1 and no halt or branch, drive operation=01 and fetch_valid=0, and remain in RUN.
REQ-027 SHALL, in RUN on advance with count_in!=LAST_ADDR, drive operation=10, value=count_in and fetch_valid=1.
REQ-028 SHALL, in RUN on advance with count_in==LAST_ADDR, drive operation=00, value=START_ADDR, fetch_valid=1 and wrap=1.
REQ-029 SHALL, in BRANCH (one bubble cycle), drive operation=01 and fetch_valid=0, then go to HALTED if halt=1, else to RUN; stall and branch_req SHALL be ignored in BRANCH.
REQ-030 SHALL, in HALTED, drive counter_enable=1, operation=01, fetch_valid=0 and done=1, go to LOAD on start=1, and otherwise hold.
REQ-031 SHALL drive counter_enable=1 in every state except IDLE.
REQ-032 SHALL perform all address arithmetic modulo 16 inside the counter; the sequencer itself SHALL never emit operation=11.
REQ-033 SHALL ignore start outside IDLE and HALTED.

Reset
REQ-034 SHALL, when reset=1 at a rising edge, force the FSM to IDLE regardless of state or other inputs, including mid-RUN and mid-BRANCH.
REQ-035 SHALL, after reset, present the IDLE output values of REQ-020, so the counter clears to 0 on the following edge.
REQ-036 SHALL treat reset=1 with start=1 as reset; start SHALL be honoured only on the first edge with reset=0.

Verification
REQ-037 SHALL pass this case: reset, then start at cycle 0 -> LOAD at cycle 1 (op=00, value=0); RUN from cycle 2 with fetch_valid=1; count_in steps 0,1,2,3 on successive cycles.
REQ-038 SHALL pass this case: running at count_in=5 with stall=1 for 3 cycles -> op=01 and fetch_valid=0 for 3 cycles, count_in stays 5, then resumes at 6.
REQ-039 SHALL pass this case: branch_req=1, branch_target=4'hA at count_in=3 -> op=00 value=A, then a BRANCH bubble with fetch_valid=0, then RUN with fetch_valid=1, count_in=A, then B.
REQ-040 SHALL pass this case: LAST_ADDR=4'h7 with count_in reaching 7 -> wrap=1 for exactly one cycle, op=00, value=START_ADDR, next count_in=0.
REQ-041 SHALL pass this case: halt and branch_req together at count_in=9 -> HALTED with done=1 and count_in held at 9; a later start reloads START_ADDR through LOAD.
REQ-042 SHALL pass this case: reset=1 asserted in BRANCH -> IDLE on the next edge with counter_enable=0, and count_in=0 one edge later.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: a Mealy FSM that steers an external 4-bit
// counter (load / hold / increment) through load, run, branch and halt
// phases. The counter's current value returns on count_in.
module pc_sequencer #(
    parameter logic [3:0] START_ADDR = 4'h0,
    parameter logic [3:0] LAST_ADDR  = 4'hF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       stall,
    input  logic       branch_req,
    input  logic [3:0] branch_target,
    input  logic       halt,
    input  logic [3:0] count_in,
    output logic       counter_enable,
    output logic [1:0] operation,
    output logic [3:0] value,
    output logic       fetch_valid,
    output logic       wrap,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_LOAD   = 3'b001,
        S_RUN    = 3'b010,
        S_BRANCH = 3'b011,
        S_HALTED = 3'b100
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_HOLD = 2'b01,
        OP_INC  = 2'b10,
        OP_DEC  = 2'b11
    } op_t;

    state_t r_state;
    state_t w_next;
    op_t    w_op;

    assign operation = w_op;

    // State register; synchronous reset overrides every other input.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and counter control from current state and inputs.
    always_comb begin
        w_next         = S_IDLE;
        counter_enable = 1'b0;
        w_op           = OP_HOLD;
        value          = '0;
        fetch_valid    = 1'b0;
        wrap           = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_next = start ? S_LOAD : S_IDLE;
            end

            S_LOAD: begin
                counter_enable = 1'b1;
                busy           = 1'b1;
                w_op           = OP_LOAD;
                value          = START_ADDR;
                w_next         = S_RUN;
            end

            S_RUN: begin
                counter_enable = 1'b1;
                busy           = 1'b1;
                if (halt) begin
                    w_op        = OP_HOLD;
                    fetch_valid = 1'b1;
                    w_next      = S_HALTED;
                end else if (branch_req) begin
                    w_op   = OP_LOAD;
                    value  = branch_target;
                    w_next = S_BRANCH;
                end else if (stall) begin
                    w_op   = OP_HOLD;
                    w_next = S_RUN;
                end else if (count_in == LAST_ADDR) begin
                    w_op        = OP_LOAD;
                    value       = START_ADDR;
                    fetch_valid = 1'b1;
                    wrap        = 1'b1;
                    w_next      = S_RUN;
                end else begin
                    w_op        = OP_INC;
                    value       = count_in;
                    fetch_valid = 1'b1;
                    w_next      = S_RUN;
                end
            end

            S_BRANCH: begin
                counter_enable = 1'b1;
                busy           = 1'b1;
                w_op           = OP_HOLD;
                w_next         = halt ? S_HALTED : S_RUN;
            end

            S_HALTED: begin
                counter_enable = 1'b1;
                done           = 1'b1;
                w_op           = OP_HOLD;
                w_next         = start ? S_LOAD : S_HALTED;
            end

            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: two instances (default range and LAST_ADDR=7),
// each closing the loop through a 4-bit counter, checked every cycle
// against an address-level model plus directed literal expectations.
module tb_pc_sequencer;

    localparam int PH_IDLE   = 0;
    localparam int PH_LOAD   = 1;
    localparam int PH_RUN    = 2;
    localparam int PH_BRANCH = 3;
    localparam int PH_HALT   = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       stall;
    logic       branch_req;
    logic [3:0] branch_target;
    logic       halt;

    logic [1:0]      ce;
    logic [1:0][1:0] op;
    logic [1:0][3:0] val;
    logic [1:0]      fv;
    logic [1:0]      wr;
    logic [1:0]      bz;
    logic [1:0]      dn;
    logic [1:0][3:0] cnt = '0;

    logic [3:0] start_p [2];
    logic [3:0] last_p  [2];

    int tests_run    = 0;
    int tests_failed = 0;

    int         m_ph  [2];
    logic [3:0] m_pc  [2];
    int         n_ph  [2];
    logic [3:0] n_pc  [2];
    bit         m_valid = 1'b0;

    always #5 clock = ~clock;

    pc_sequencer u_dut0 (
        .clock(clock), .reset(reset), .start(start), .stall(stall),
        .branch_req(branch_req), .branch_target(branch_target), .halt(halt),
        .count_in(cnt[0]), .counter_enable(ce[0]), .operation(op[0]),
        .value(val[0]), .fetch_valid(fv[0]), .wrap(wr[0]), .busy(bz[0]),
        .done(dn[0])
    );

    pc_sequencer #(.START_ADDR(4'h0), .LAST_ADDR(4'h7)) u_dut1 (
        .clock(clock), .reset(reset), .start(start), .stall(stall),
        .branch_req(branch_req), .branch_target(branch_target), .halt(halt),
        .count_in(cnt[1]), .counter_enable(ce[1]), .operation(op[1]),
        .value(val[1]), .fetch_valid(fv[1]), .wrap(wr[1]), .busy(bz[1]),
        .done(dn[1])
    );

    // External counters driven by each sequencer.
    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (!ce[k]) cnt[k] <= '0;
            else begin
                case (op[k])
                    2'b00: cnt[k] <= val[k];
                    2'b10: cnt[k] <= val[k] + 4'd1;
                    2'b11: cnt[k] <= val[k] - 4'd1;
                    default: cnt[k] <= cnt[k];
                endcase
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: what the sequencer must emit for a phase and fetch address,
    // and where the address and phase go next.
    function automatic void model(input int ph, input logic [3:0] pc,
                                  input logic [3:0] st, input logic [3:0] la,
                                  output logic [10:0] o, output int nph,
                                  output logic [3:0] npc);
        logic c, f, w, b, d;
        logic [1:0] p;
        logic [3:0] v;
        c = 1'b1; p = 2'b01; v = 4'h0; f = 1'b0; w = 1'b0; b = 1'b0; d = 1'b0;
        nph = ph; npc = pc;
        if (ph == PH_IDLE) begin
            c = 1'b0; npc = 4'h0;
            nph = start ? PH_LOAD : PH_IDLE;
        end else if (ph == PH_LOAD) begin
            b = 1'b1; p = 2'b00; v = st; npc = st; nph = PH_RUN;
        end else if (ph == PH_RUN) begin
            b = 1'b1;
            if (halt) begin
                f = 1'b1; nph = PH_HALT;
            end else if (branch_req) begin
                p = 2'b00; v = branch_target; npc = branch_target; nph = PH_BRANCH;
            end else if (!stall) begin
                f = 1'b1;
                if (pc == la) begin
                    p = 2'b00; v = st; w = 1'b1; npc = st;
                end else begin
                    p = 2'b10; v = pc; npc = pc + 4'd1;
                end
            end
        end else if (ph == PH_BRANCH) begin
            b = 1'b1; nph = halt ? PH_HALT : PH_RUN;
        end else begin
            d = 1'b1; nph = start ? PH_LOAD : PH_HALT;
        end
        o = {c, p, v, f, w, b, d};
    endfunction

    // Per-cycle comparison against the model, away from the clock edge.
    always @(negedge clock) begin
        if (m_valid) begin
            for (int k = 0; k < 2; k++) begin
                logic [10:0] e, a;
                int         np;
                logic [3:0] nc;
                model(m_ph[k], m_pc[k], start_p[k], last_p[k], e, np, nc);
                a = {ce[k], op[k], val[k], fv[k], wr[k], bz[k], dn[k]};
                if (e[9:8] == 2'b01) begin
                    e[7:4] = 4'h0;
                    a[7:4] = 4'h0;
                end
                chk($sformatf("model_outs[%0d]", k), {5'd0, a}, {5'd0, e});
                chk($sformatf("model_count[%0d]", k), {12'd0, cnt[k]}, {12'd0, m_pc[k]});
                n_ph[k] <= np;
                n_pc[k] <= nc;
            end
        end
    end

    // Model state update on the active edge.
    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (m_valid) begin
                m_pc[k] <= n_pc[k];
                m_ph[k] <= reset ? PH_IDLE : n_ph[k];
            end else if (reset) begin
                m_pc[k] <= 4'h0;
                m_ph[k] <= PH_IDLE;
            end
        end
        if (reset) m_valid <= 1'b1;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        start_p[0] = 4'h0; last_p[0] = 4'hF;
        start_p[1] = 4'h0; last_p[1] = 4'h7;
        m_pc[0] = 4'h0; m_pc[1] = 4'h0;
        m_ph[0] = PH_IDLE; m_ph[1] = PH_IDLE;
        reset = 1'b1; start = 1'b0; stall = 1'b0; branch_req = 1'b0;
        branch_target = 4'h0; halt = 1'b0;
        tick; tick;

        // reset together with start stays in IDLE
        start = 1'b1;
        tick;
        reset = 1'b0;
        #1;
        chk("idle_busy", {15'd0, bz[0]}, 16'd0);
        chk("idle_ce", {15'd0, ce[0]}, 16'd0);

        // start -> LOAD -> RUN counting 0..3
        tick;
        start = 1'b0;
        #1;
        chk("load_op", {14'd0, op[0]}, 16'h0);
        chk("load_value", {12'd0, val[0]}, 16'h0);
        tick; #1;
        chk("run_fv", {15'd0, fv[0]}, 16'd1);
        chk("run_cnt0", {12'd0, cnt[0]}, 16'h0);
        for (int i = 1; i <= 3; i++) begin
            tick; #1;
            chk($sformatf("run_cnt%0d", i), {12'd0, cnt[0]}, i[15:0]);
        end
        tick; tick; #1;
        chk("pre_stall_cnt", {12'd0, cnt[0]}, 16'h5);

        // three stall cycles at 5, then resume at 6
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_op", {14'd0, op[0]}, 16'h1);
            chk("stall_fv", {15'd0, fv[0]}, 16'd0);
            chk("stall_cnt", {12'd0, cnt[0]}, 16'h5);
            tick;
        end
        stall = 1'b0;
        tick; #1;
        chk("resume_cnt", {12'd0, cnt[0]}, 16'h6);

        // start ignored in RUN; wrap at 7 on the LAST_ADDR=7 instance
        start = 1'b1;
        tick;
        start = 1'b0;
        #1;
        chk("wrap7_pulse", {15'd0, wr[1]}, 16'd1);
        chk("wrap7_op", {14'd0, op[1]}, 16'h0);
        chk("wrap7_value", {12'd0, val[1]}, 16'h0);
        chk("nowrap_F_op", {14'd0, op[0]}, 16'h2);
        tick; #1;
        chk("wrap7_cnt", {12'd0, cnt[1]}, 16'h0);
        chk("wrap7_clear", {15'd0, wr[1]}, 16'd0);
        chk("cnt8", {12'd0, cnt[0]}, 16'h8);

        // branch to A; stall/branch_req ignored during the bubble
        branch_req = 1'b1; branch_target = 4'hA;
        #1;
        chk("br_op", {14'd0, op[0]}, 16'h0);
        chk("br_value", {12'd0, val[0]}, 16'hA);
        chk("br_fv", {15'd0, fv[0]}, 16'd0);
        tick;
        branch_target = 4'h5; stall = 1'b1;
        #1;
        chk("bubble_fv", {15'd0, fv[0]}, 16'd0);
        chk("bubble_op", {14'd0, op[0]}, 16'h1);
        tick;
        branch_req = 1'b0; stall = 1'b0;
        #1;
        chk("post_br_fv", {15'd0, fv[0]}, 16'd1);
        chk("post_br_cnt", {12'd0, cnt[0]}, 16'hA);
        tick; #1;
        chk("post_br_next", {12'd0, cnt[0]}, 16'hB);

        // halt beats branch at 9
        branch_req = 1'b1; branch_target = 4'h8;
        tick;
        branch_req = 1'b0;
        tick; tick; #1;
        chk("cnt9", {12'd0, cnt[0]}, 16'h9);
        halt = 1'b1; branch_req = 1'b1; branch_target = 4'h2;
        #1;
        chk("halt_op", {14'd0, op[0]}, 16'h1);
        chk("halt_fv", {15'd0, fv[0]}, 16'd1);
        tick;
        halt = 1'b0; branch_req = 1'b0;
        #1;
        chk("halted_done", {15'd0, dn[0]}, 16'd1);
        chk("halted_cnt", {12'd0, cnt[0]}, 16'h9);
        tick; #1;
        chk("halted_hold", {12'd0, cnt[0]}, 16'h9);
        start = 1'b1;
        tick;
        start = 1'b0;
        #1;
        chk("reload_op", {14'd0, op[0]}, 16'h0);
        chk("reload_value", {12'd0, val[0]}, 16'h0);
        tick; #1;
        chk("reload_cnt", {12'd0, cnt[0]}, 16'h0);

        // halt during the branch bubble
        branch_req = 1'b1; branch_target = 4'h4;
        tick;
        branch_req = 1'b0; halt = 1'b1;
        tick;
        halt = 1'b0;
        #1;
        chk("br_halt_done", {15'd0, dn[0]}, 16'd1);
        chk("br_halt_cnt", {12'd0, cnt[0]}, 16'h4);
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;

        // wrap at F on the default instance
        branch_req = 1'b1; branch_target = 4'hE;
        tick;
        branch_req = 1'b0;
        tick; tick; #1;
        chk("wrapF_pulse", {15'd0, wr[0]}, 16'd1);
        chk("wrapF_value", {12'd0, val[0]}, 16'h0);
        chk("F_inc_on_7", {14'd0, op[1]}, 16'h2);
        tick; #1;
        chk("wrapF_cnt", {12'd0, cnt[0]}, 16'h0);
        chk("wrapF_clear", {15'd0, wr[0]}, 16'd0);

        // reset during the branch bubble
        branch_req = 1'b1; branch_target = 4'h6;
        tick;
        branch_req = 1'b0; reset = 1'b1;
        tick;
        reset = 1'b0;
        #1;
        chk("rst_br_ce", {15'd0, ce[0]}, 16'd0);
        chk("rst_br_cnt", {12'd0, cnt[0]}, 16'h6);
        tick; #1;
        chk("rst_br_clear", {12'd0, cnt[0]}, 16'h0);
        tick; tick;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
